// File: rtl/tx_queue_pkg.sv
// Shared definitions for the router output path: packet word type used by
// the router core, tx_queue and tx_handshake.
package tx_queue_pkg;

    localparam int DATA_W = 55;

    typedef logic [DATA_W-1:0] pkt_word_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tx_queue_if.sv
// Push side (router core) and pop side (tx_handshake) of the TX queue.
// master = the environment around the queue, slave = the queue itself.
interface tx_queue_if
    import tx_queue_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic             wr_en;
    pkt_word_t        wr_data;
    logic             full;
    logic             almost_full;
    logic [CNT_W-1:0] count;
    logic             flush;
    logic             ovf_err;
    logic             tx_ready;
    logic             rc_has_data;
    pkt_word_t        data_to_tx;

    modport master (
        output wr_en, wr_data, flush, tx_ready,
        input  full, almost_full, count, ovf_err, rc_has_data, data_to_tx
    );

    modport slave (
        input  wr_en, wr_data, flush, tx_ready,
        output full, almost_full, count, ovf_err, rc_has_data, data_to_tx
    );

endinterface

// File: rtl/tx_queue_mem.sv
// Queue storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module tx_queue_mem
    import tx_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  pkt_word_t                i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output pkt_word_t                o_rdata
);

    pkt_word_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tx_queue.sv
// Show-ahead FIFO between the router core and tx_handshake. Head word is
// presented from the registered read pointer; flags decode the count register only.
module tx_queue
    import tx_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6
) (
    input logic       clk,
    input logic       rst,
    tx_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LP_AFULL = CNT_W'(AFULL_LVL);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf_err;

    logic      w_full;
    logic      w_has_data;
    logic      w_pop;
    logic      w_push;
    logic      w_ovf;
    logic      w_we;
    pkt_word_t w_head;

    assign w_full     = (r_count == LP_DEPTH);
    assign w_has_data = (r_count != '0);
    assign w_pop      = bus.tx_ready && w_has_data;
    assign w_push     = bus.wr_en && (!w_full || w_pop);
    assign w_ovf      = bus.wr_en && w_full && !w_pop;
    // flush drops any word offered in the same cycle, so the memory write is gated too
    assign w_we       = w_push && !bus.flush && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf_err <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    tx_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign bus.full        = w_full;
    assign bus.almost_full = (r_count >= LP_AFULL);
    assign bus.count       = r_count;
    assign bus.ovf_err     = r_ovf_err;
    assign bus.rc_has_data = w_has_data;
    assign bus.data_to_tx  = w_has_data ? w_head : '0;

endmodule

// File: tb/tb_tx_queue.sv
// Bench for tx_queue: fixed vector table, directed corner sequences and a
// randomized tx_handshake scenario checked against a queue-based model.
module tb_tx_queue;
    import tx_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_queue_if #(.DEPTH(DEPTH)) bus();

    tx_queue #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    pkt_word_t m_q[$];
    logic      m_ovf;
    pkt_word_t m_popped[$];
    pkt_word_t delivered[$];

    typedef struct {
        logic      rst;
        logic      wr;
        pkt_word_t d;
        logic      tr;
        logic      fl;
        int        cnt;
        logic      has;
        pkt_word_t dat;
        logic      ovf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = m_q.size();
        chk("count", 64'(bus.count), 64'(sz));
        chk("full", 64'(bus.full), 64'(sz == DEPTH));
        chk("almost_full", 64'(bus.almost_full), 64'(sz >= AFULL));
        chk("rc_has_data", 64'(bus.rc_has_data), 64'(sz != 0));
        chk("data_to_tx", 64'(bus.data_to_tx), (sz != 0) ? 64'(m_q[0]) : 64'd0);
        chk("ovf_err", 64'(bus.ovf_err), 64'(m_ovf));
    endtask

    // One clock: drive inputs, record the accepted word, advance the model, check at negedge.
    task automatic cycle(input logic r, input logic w, input pkt_word_t d,
                         input logic t, input logic f);
        logic pop, full, push;
        rst         = r;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.tx_ready = t;
        bus.flush   = f;
        if (!r && !f && t && bus.rc_has_data) delivered.push_back(bus.data_to_tx);
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else if (f) begin
            m_q.delete();
        end else begin
            pop  = t && (m_q.size() != 0);
            full = (m_q.size() == DEPTH);
            push = w && (!full || pop);
            if (w && full && !pop) m_ovf = 1'b1;
            if (pop) m_popped.push_back(m_q.pop_front());
            if (push) m_q.push_back(d);
        end
        @(negedge clk);
        check_model();
    endtask

    function automatic pkt_word_t rnd_word();
        return pkt_word_t'({$urandom, $urandom});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hold;
        logic tr;
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.tx_ready = 1'b0;
        bus.flush = 1'b0;
        m_ovf = 1'b0;

        // reset with wr_en high, push 1,2,3, then pop them one per cycle
        tbl[0] = '{1, 1, 55'hAA, 0, 0, 0, 0, 55'h0, 0};
        tbl[1] = '{1, 1, 55'hBB, 0, 0, 0, 0, 55'h0, 0};
        tbl[2] = '{0, 1, 55'h1,  0, 0, 1, 1, 55'h1, 0};
        tbl[3] = '{0, 1, 55'h2,  0, 0, 2, 1, 55'h1, 0};
        tbl[4] = '{0, 1, 55'h3,  0, 0, 3, 1, 55'h1, 0};
        tbl[5] = '{0, 0, 55'h0,  1, 0, 2, 1, 55'h2, 0};
        tbl[6] = '{0, 0, 55'h0,  1, 0, 1, 1, 55'h3, 0};
        tbl[7] = '{0, 0, 55'h0,  1, 0, 0, 0, 55'h0, 0};
        tbl[8] = '{0, 0, 55'h0,  1, 0, 0, 0, 55'h0, 0};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].rst, tbl[i].wr, tbl[i].d, tbl[i].tr, tbl[i].fl);
            chk("tbl_count", 64'(bus.count), 64'(tbl[i].cnt));
            chk("tbl_has", 64'(bus.rc_has_data), 64'(tbl[i].has));
            chk("tbl_data", 64'(bus.data_to_tx), 64'(tbl[i].dat));
            chk("tbl_ovf", 64'(bus.ovf_err), 64'(tbl[i].ovf));
        end

        // fill to DEPTH, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, pkt_word_t'(64'h100 + i), 0, 0);
        chk("fill_full", 64'(bus.full), 64'd1);
        chk("fill_count", 64'(bus.count), 64'd8);
        chk("fill_ovf0", 64'(bus.ovf_err), 64'd0);
        cycle(0, 1, 55'h7FFF, 0, 0);
        chk("ovf_set", 64'(bus.ovf_err), 64'd1);
        chk("ovf_count", 64'(bus.count), 64'd8);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, '0, 1, 0);
        chk("drain_empty", 64'(bus.rc_has_data), 64'd0);

        // flush with simultaneous push and pop; ovf_err must survive
        for (int i = 0; i < 5; i++) cycle(0, 1, pkt_word_t'(64'h200 + i), 0, 0);
        cycle(0, 1, 55'h2FF, 1, 1);
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_has", 64'(bus.rc_has_data), 64'd0);
        chk("flush_ovf", 64'(bus.ovf_err), 64'd1);
        cycle(0, 0, '0, 1, 0);

        // simultaneous push/pop at full
        cycle(1, 0, '0, 0, 0);
        chk("rst_ovf_clear", 64'(bus.ovf_err), 64'd0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, pkt_word_t'(64'h300 + i), 0, 0);
        cycle(0, 1, 55'h3AA, 1, 0);
        chk("full_pp_count", 64'(bus.count), 64'd8);
        chk("full_pp_ovf", 64'(bus.ovf_err), 64'd0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, '0, 1, 0);

        // pointer wrap at steady level 3
        for (int i = 0; i < 3; i++) cycle(0, 1, pkt_word_t'(64'h400 + i), 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, pkt_word_t'(64'h410 + i), 1, 0);
        chk("wrap_count", 64'(bus.count), 64'd3);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 0);

        // tx_handshake model: ready until an accept, then low for 3 cycles
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            tr = (hold == 0);
            if (hold > 0) hold--;
            if (tr && m_q.size() != 0) hold = 3;
            cycle(0, 1'($urandom_range(0, 1)), rnd_word(), tr, ($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, '0, 1, 0);

        chk("sb_size", 64'(delivered.size()), 64'(m_popped.size()));
        for (int i = 0; i < delivered.size() && i < m_popped.size(); i++)
            chk("sb_word", 64'(delivered[i]), 64'(m_popped[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
